sampled_history_tracker: RTL and testbench
==========================================

Name: sampled_history_tracker

Overview:
- Sequential companion stage that sits upstream of the $sampled consumers.
- Holds a per-signal history of sampled values.
- Produces registered $past-style delayed values and $rose/$fell/$stable/$changed-style flags for downstream assertion and check logic.
- Sampling is qualified by an enable (gating expression), so history advances only on enabled ticks.

Parameters:
- WIDTH, 8: bit width of the tracked signal (>=1).
- DEPTH, 4: $past delay in enabled ticks (>=1); history register count.
- CNT_W, 16: width of the saturating change counter (>=2).

Ports:
- clk  input  1  sampling clock; all state updates on posedge.
- rst  input  1  reset: synchronous and active-high; one clock.
- en  input  1  sample enable (gating); history and flags advance only when 1.
- in_val  input  WIDTH  signal to be sampled.
- past_val  output  WIDTH  value sampled DEPTH enabled ticks ago (hist[DEPTH-1]).
- past_valid  output  1  1 once DEPTH enabled samples have been captured since reset.
- hist_fill  output  $clog2(DEPTH+1)  number of captured samples, saturating at DEPTH.
- rose  output  1  LSB went 0->1 between the previous and the current sample.
- fell  output  1  LSB went 1->0 between the previous and the current sample.
- stable  output  1  current sample equals the previous sample (full WIDTH).
- changed_count  output  CNT_W  enabled ticks on which the sample differed from the previous one; saturating.

Behaviour:
- Reset (rst=1 at posedge): hist[0..DEPTH-1]=0, hist_fill=0, past_val=0, past_valid=0, rose=0, fell=0, stable=0, changed_count=0. Reset wins over en.
- Enabled tick (rst=0, en=1), all updates registered with 1-cycle latency, computed from pre-edge state:
  - hist[0]<=in_val; hist[i]<=hist[i-1] for i=1..DEPTH-1.
  - hist_fill<=min(hist_fill+1, DEPTH).
  - prev_ok := (hist_fill>=1).
  - rose<=prev_ok & ~hist[0][0] & in_val[0].
  - fell<=prev_ok & hist[0][0] & ~in_val[0].
  - stable<=prev_ok & (in_val==hist[0]).
  - If prev_ok & (in_val!=hist[0]) and changed_count != all-ones: changed_count<=changed_count+1. At all-ones it holds; it never wraps.
- First sample after reset: prev_ok=0, so rose=fell=stable=0 and there is no count, even if in_val differs from the reset value 0.
- Disabled tick (en=0): all state and all outputs hold. Flags are not cleared; they describe the last enabled tick.
- past_val: continuous copy of hist[DEPTH-1], so it is registered. Equals 0 until DEPTH enabled samples have been taken.
- past_valid: 1 iff hist_fill==DEPTH. It rises on the same edge that loads the DEPTH-th sample into the last history slot.
- DEPTH=1: past_val equals the previous sample; past_valid rises after the first enabled tick.
- Mutual exclusion: rose and fell are never both 1. stable=1 implies rose=fell=0 and no count increment.
- Reset mid-operation: the entire history is discarded and the first-sample rule applies again.
- No X propagation: all state is explicitly reset.
- No combinational path from in_val to any output.

Test Plan:
1. Reset, then en=1 and in_val=8'h11,22,33,44,55 on consecutive cycles -> past_valid=0 until the edge loading 8'h44, then 1. After that edge past_val=8'h11; after the 8'h55 edge past_val=8'h22. hist_fill=4, changed_count=4.
2. en=1, in_val LSB sequence 0,1,1,0 after reset -> after the 1st edge rose=fell=stable=0. After the 2nd edge rose=1. After the 3rd edge stable=1 and rose=0. After the 4th edge fell=1. changed_count=2.
3. Gating: samples 8'hA0,8'hA1, then en=0 for 5 cycles while in_val toggles, then en=1 with 8'hA1 -> outputs frozen during en=0. The next edge gives stable=1, changed_count=1, hist_fill=3.
4. Saturation with CNT_W=2: alternate in_val between 0 and 1 for 6 enabled ticks -> changed_count reaches 3 and holds 3; it never wraps to 0.
5. Reset mid-stream: after 3 samples, assert rst for one cycle with en=1 and in_val=8'hFF -> all outputs 0 after that edge. The next enabled sample 8'hFF gives rose=0 and changed_count=0.
6. DEPTH=1, in_val=8'h5A then 8'h5A -> past_valid=1 after the 1st edge, past_val=8'h5A, and stable=1 after the 2nd edge.

Source files
------------

// File: rtl/sampled_history_tracker.sv
// Sampled-value history stage: keeps the last DEPTH enabled samples and produces registered
// $past-style delayed values plus $rose/$fell/$stable/$changed-style flags for checkers.
module sampled_history_tracker #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [WIDTH-1:0]           in_val,
   output logic [WIDTH-1:0]           past_val,
   output logic                       past_valid,
   output logic [$clog2(DEPTH+1)-1:0] hist_fill,
   output logic                       rose,
   output logic                       fell,
   output logic                       stable,
   output logic [CNT_W-1:0]           changed_count
);

   localparam int unsigned FillW = $clog2(DEPTH + 1);
   localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);

   // Flattened history: slot 0 (newest) in the low WIDTH bits, slot DEPTH-1 at the top.
   logic [DEPTH*WIDTH-1:0] hist_q, hist_d;
   logic [FillW-1:0]       fill_q, fill_d;
   logic                   rose_q, rose_d;
   logic                   fell_q, fell_d;
   logic                   stable_q, stable_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [WIDTH-1:0] newest;
   logic             prev_ok;
   logic             differs;

   always_comb begin
      hist_d   = hist_q;
      fill_d   = fill_q;
      rose_d   = rose_q;
      fell_d   = fell_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      newest   = hist_q[WIDTH-1:0];
      prev_ok  = (fill_q != '0);
      differs  = (in_val != newest);
      if (en) begin
         hist_d              = hist_q << WIDTH;
         hist_d[WIDTH-1:0]   = in_val;
         if (fill_q != FillMax) begin
            fill_d = fill_q + 1'b1;
         end
         rose_d   = prev_ok & ~newest[0] & in_val[0];
         fell_d   = prev_ok & newest[0] & ~in_val[0];
         stable_d = prev_ok & ~differs;
         // Saturate rather than wrap so a long run never reads as "few changes".
         if (prev_ok && differs && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q   <= '0;
         fill_q   <= '0;
         rose_q   <= 1'b0;
         fell_q   <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         hist_q   <= hist_d;
         fill_q   <= fill_d;
         rose_q   <= rose_d;
         fell_q   <= fell_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign past_val      = hist_q[DEPTH*WIDTH-1 -: WIDTH];
   assign past_valid    = (fill_q == FillMax);
   assign hist_fill     = fill_q;
   assign rose          = rose_q;
   assign fell          = fell_q;
   assign stable        = stable_q;
   assign changed_count = cnt_q;

endmodule

// File: tb/tb_sampled_history_tracker.sv
// Bench for sampled_history_tracker: three parameterisations driven by shared stimulus and
// checked each cycle against a sample-list model, plus literal expectations for key cases.
module tb_sampled_history_tracker;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] in_val;

   logic [7:0]  a_past, b_past, c_past;
   logic        a_pv, b_pv, c_pv;
   logic [2:0]  a_fill, b_fill;
   logic [0:0]  c_fill;
   logic        a_rose, b_rose, c_rose;
   logic        a_fell, b_fell, c_fell;
   logic        a_stab, b_stab, c_stab;
   logic [15:0] a_cnt, c_cnt;
   logic [1:0]  b_cnt;

   int n_pass  = 0;
   int n_total = 0;
   bit check_on = 1'b0;

   // Model: every enabled sample since the last reset (newest at the back, last 8 kept).
   logic [7:0] smp[$];
   int         n_smp = 0;
   int         n_chg = 0;

   sampled_history_tracker #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) u_d4 (
      .clk(clk), .rst(rst), .en(en), .in_val(in_val),
      .past_val(a_past), .past_valid(a_pv), .hist_fill(a_fill),
      .rose(a_rose), .fell(a_fell), .stable(a_stab), .changed_count(a_cnt)
   );

   sampled_history_tracker #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .en(en), .in_val(in_val),
      .past_val(b_past), .past_valid(b_pv), .hist_fill(b_fill),
      .rose(b_rose), .fell(b_fell), .stable(b_stab), .changed_count(b_cnt)
   );

   sampled_history_tracker #(.WIDTH(8), .DEPTH(1), .CNT_W(16)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .in_val(in_val),
      .past_val(c_past), .past_valid(c_pv), .hist_fill(c_fill),
      .rose(c_rose), .fell(c_fell), .stable(c_stab), .changed_count(c_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   always @(posedge clk) begin
      if (rst) begin
         smp.delete();
         n_smp = 0;
         n_chg = 0;
      end else if (en) begin
         if (n_smp >= 1 && in_val != smp[smp.size()-1]) n_chg++;
         smp.push_back(in_val);
         if (smp.size() > 8) void'(smp.pop_front());
         n_smp++;
      end
   end

   task automatic check_inst(input string tag, input int d, input int cw,
                             input logic [7:0] pv, input logic pvld, input logic [31:0] fill,
                             input logic r, input logic f, input logic s,
                             input logic [31:0] cnt);
      int         sz;
      logic [7:0] e_past;
      logic       e_r, e_f, e_s;
      int         e_cnt;
      int         cmax;
      sz     = smp.size();
      e_past = (n_smp >= d) ? smp[sz-d] : 8'h00;
      e_r    = (n_smp >= 2) && !smp[sz-2][0] && smp[sz-1][0];
      e_f    = (n_smp >= 2) && smp[sz-2][0] && !smp[sz-1][0];
      e_s    = (n_smp >= 2) && (smp[sz-2] == smp[sz-1]);
      cmax   = (1 << cw) - 1;
      e_cnt  = (n_chg > cmax) ? cmax : n_chg;
      chk({tag, ".past_val"}, 32'(pv), 32'(e_past));
      chk({tag, ".past_valid"}, 32'(pvld), 32'(n_smp >= d));
      chk({tag, ".hist_fill"}, fill, 32'((n_smp < d) ? n_smp : d));
      chk({tag, ".rose"}, 32'(r), 32'(e_r));
      chk({tag, ".fell"}, 32'(f), 32'(e_f));
      chk({tag, ".stable"}, 32'(s), 32'(e_s));
      chk({tag, ".changed_count"}, cnt, 32'(e_cnt));
   endtask

   always @(negedge clk) begin
      if (check_on) begin
         check_inst("d4", 4, 16, a_past, a_pv, 32'(a_fill), a_rose, a_fell, a_stab, 32'(a_cnt));
         check_inst("c2", 4, 2, b_past, b_pv, 32'(b_fill), b_rose, b_fell, b_stab, 32'(b_cnt));
         check_inst("d1", 1, 16, c_past, c_pv, 32'(c_fill), c_rose, c_fell, c_stab, 32'(c_cnt));
      end
   end

   // Inputs change at the falling edge; checks after step() look just past the rising edge.
   task automatic step(input logic r, input logic e, input logic [7:0] v);
      @(negedge clk);
      rst    = r;
      en     = e;
      in_val = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      en     = 1'b0;
      in_val = 8'h00;
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h3C);
      chk("reset.past_valid", 32'(a_pv), 32'd0);
      chk("reset.changed_count", 32'(a_cnt), 32'd0);
      check_on = 1'b1;

      // Fill and $past latency.
      step(1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b1, 8'h22);
      step(1'b0, 1'b1, 8'h33);
      chk("t1.pv_before", 32'(a_pv), 32'd0);
      chk("t1.past_before", 32'(a_past), 32'h00);
      step(1'b0, 1'b1, 8'h44);
      chk("t1.pv_at_44", 32'(a_pv), 32'd1);
      chk("t1.past_at_44", 32'(a_past), 32'h11);
      step(1'b0, 1'b1, 8'h55);
      chk("t1.past_at_55", 32'(a_past), 32'h22);
      chk("t1.fill", 32'(a_fill), 32'd4);
      chk("t1.count", 32'(a_cnt), 32'd4);

      // Edge flags on LSB sequence 0,1,1,0.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h10);
      chk("t2.first_flags", 32'({a_rose, a_fell, a_stab}), 32'd0);
      step(1'b0, 1'b1, 8'h11);
      chk("t2.rose", 32'(a_rose), 32'd1);
      step(1'b0, 1'b1, 8'h11);
      chk("t2.stable_rose", 32'({a_stab, a_rose}), 32'b10);
      step(1'b0, 1'b1, 8'h10);
      chk("t2.fell", 32'(a_fell), 32'd1);
      chk("t2.count", 32'(a_cnt), 32'd2);

      // Gating: frozen while disabled.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hA0);
      step(1'b0, 1'b1, 8'hA1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'(i * 37 + 1));
      chk("t3.frozen_rose", 32'(a_rose), 32'd1);
      chk("t3.frozen_fill", 32'(a_fill), 32'd2);
      step(1'b0, 1'b1, 8'hA1);
      chk("t3.stable", 32'(a_stab), 32'd1);
      chk("t3.count", 32'(a_cnt), 32'd1);
      chk("t3.fill", 32'(a_fill), 32'd3);

      // Counter saturation at CNT_W=2.
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 8'(i % 2));
         if (i == 3) chk("t4.count_reach3", 32'(b_cnt), 32'd3);
      end
      chk("t4.count_hold3", 32'(b_cnt), 32'd3);

      // Reset mid-stream wins over en.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h01);
      step(1'b0, 1'b1, 8'h02);
      step(1'b0, 1'b1, 8'h03);
      step(1'b1, 1'b1, 8'hFF);
      chk("t5.all_zero", 32'({a_past, a_pv, a_fill, a_rose, a_fell, a_stab, a_cnt}), 32'd0);
      step(1'b0, 1'b1, 8'hFF);
      chk("t5.rose", 32'(a_rose), 32'd0);
      chk("t5.count", 32'(a_cnt), 32'd0);
      chk("t5.fill", 32'(a_fill), 32'd1);

      // DEPTH=1.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h5A);
      chk("t6.pv", 32'(c_pv), 32'd1);
      chk("t6.past", 32'(c_past), 32'h5A);
      step(1'b0, 1'b1, 8'h5A);
      chk("t6.stable", 32'(c_stab), 32'd1);

      // Randomised traffic, small value set so stable/rose/fell all occur.
      for (int i = 0; i < 400; i++) begin
         logic       r, e;
         logic [7:0] v;
         r = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 9) < 7);
         v = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         step(r, e, v);
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
